snoopy_sprite_drawer: RTL and testbench

- Consumer of Snoopy's position: samples snoopy_x/snoopy_y once per refresh period.
- When the position has changed, it erases the sprite at the previously drawn position, then draws it at the new one.
- Emits one pixel-write per cycle to the VGA adapter's plot interface (160x120, 3-bit colour).
- Sits between the movement FSMs and the VGA adapter.

---
 rtl/snoopy_sprite_drawer.sv | 136 +++++++++++++
 tb/tb_snoopy_sprite_drawer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoopy_sprite_drawer.sv
// Sprite drawer: on each refresh tick, erases Snoopy at the last drawn position and redraws
// it at the newly sampled one, emitting one clipped pixel write per clock to the VGA adapter.
module snoopy_sprite_drawer #(
  parameter int         SPRITE_W      = 8,
  parameter int         SPRITE_H      = 8,
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] SPRITE_COLOUR = 3'b111,
  parameter int         REFRESH_DIV   = 833333
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] snoopy_x,
  input  logic [6:0] snoopy_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy
);

  localparam int                CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]        PX_LAST  = 4'(SPRITE_W - 1);
  localparam logic [3:0]        PY_LAST  = 4'(SPRITE_H - 1);
  localparam logic [8:0]        SCR_W9   = 9'(SCREEN_W);
  localparam logic [7:0]        SCR_H8   = 8'(SCREEN_H);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       px_q, px_d, py_q, py_d;
  logic [7:0]       drawn_x_q, drawn_x_d, new_x_q, new_x_d;
  logic [6:0]       drawn_y_q, drawn_y_d, new_y_q, new_y_d;
  logic             first_q, first_d;

  logic       tick, last_px, last_pix, on_screen;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  assign tick     = (cnt_q == CNT_LAST);
  assign last_px  = (px_q == PX_LAST);
  assign last_pix = last_px && (py_q == PY_LAST);

  // Free-running refresh divider, independent of the drawing state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      px_q      <= '0;
      py_q      <= '0;
      drawn_x_q <= '0;
      drawn_y_q <= '0;
      new_x_q   <= '0;
      new_y_q   <= '0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      py_q      <= py_d;
      drawn_x_q <= drawn_x_d;
      drawn_y_q <= drawn_y_d;
      new_x_q   <= new_x_d;
      new_y_q   <= new_y_d;
      first_q   <= first_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    px_d      = px_q;
    py_d      = py_q;
    drawn_x_d = drawn_x_q;
    drawn_y_d = drawn_y_q;
    new_x_d   = new_x_q;
    new_y_d   = new_y_q;
    first_d   = first_q;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          new_x_d = snoopy_x;
          new_y_d = snoopy_y;
          px_d    = '0;
          py_d    = '0;
          if (first_q)
            state_d = S_DRAW;
          else if ((snoopy_x != drawn_x_q) || (snoopy_y != drawn_y_q))
            state_d = S_ERASE;
        end
      end
      S_ERASE, S_DRAW: begin
        // Row-major scan; clipped pixels still consume their cycle.
        if (last_px) begin
          px_d = '0;
          py_d = py_q + 1'b1;
        end else begin
          px_d = px_q + 1'b1;
        end
        if (last_pix) begin
          py_d = '0;
          if (state_q == S_ERASE) begin
            state_d = S_DRAW;
          end else begin
            drawn_x_d = new_x_q;
            drawn_y_d = new_y_q;
            first_d   = 1'b0;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign base_x    = (state_q == S_ERASE) ? drawn_x_q : new_x_q;
  assign base_y    = (state_q == S_ERASE) ? drawn_y_q : new_y_q;
  assign sum_x     = {1'b0, base_x} + {5'b0, px_q};
  assign sum_y     = {1'b0, base_y} + {4'b0, py_q};
  assign on_screen = (sum_x < SCR_W9) && (sum_y < SCR_H8);

  assign plot       = busy && on_screen;
  assign vga_x      = busy ? sum_x[7:0] : 8'd0;
  assign vga_y      = busy ? sum_y[6:0] : 7'd0;
  assign vga_colour = (state_q == S_ERASE) ? BG_COLOUR :
                      (state_q == S_DRAW)  ? SPRITE_COLOUR : 3'd0;

endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
// Randomised self-checking bench for snoopy_sprite_drawer; expected pixel streams come from a
// pixel-list model of the erase/draw rules, compared cycle by cycle after each refresh tick.
module tb_snoopy_sprite_drawer;

  localparam int DIV = 200;
  localparam int SW  = 8;
  localparam int SH  = 8;
  localparam int WIN = 140;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] snoopy_x = 8'd0;
  logic [6:0] snoopy_y = 7'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  snoopy_sprite_drawer #(
    .SPRITE_W(SW), .SPRITE_H(SH), .SCREEN_W(160), .SCREEN_H(120),
    .BG_COLOUR(3'b000), .SPRITE_COLOUR(3'b111), .REFRESH_DIV(DIV)
  ) dut (
    .clock(clock), .reset(reset), .snoopy_x(snoopy_x), .snoopy_y(snoopy_y),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot), .busy(busy)
  );

  always #5 clock = ~clock;

  // Cycles since reset release; a refresh tick falls on every cycle with cyc % DIV == DIV-1.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model state and expected / observed per-cycle streams after a tick.
  bit         m_first = 1'b1;
  int         m_dx = 0, m_dy = 0, n_exp = 0;
  logic       exp_plot[WIN], exp_busy[WIN], obs_plot[WIN], obs_busy[WIN];
  logic [7:0] exp_x[WIN], obs_x[WIN];
  logic [6:0] exp_y[WIN], obs_y[WIN];
  logic [2:0] exp_col[WIN], obs_col[WIN];

  function automatic void add_phase(input int bx, input int by, input logic [2:0] col);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        exp_busy[n_exp] = 1'b1;
        exp_plot[n_exp] = ((bx + c) < 160) && ((by + r) < 120);
        exp_x[n_exp]    = 8'(bx + c);
        exp_y[n_exp]    = 7'(by + r);
        exp_col[n_exp]  = col;
        n_exp++;
      end
    end
  endfunction

  function automatic void build_expected(input int sx, input int sy);
    for (int i = 0; i < WIN; i++) begin
      exp_plot[i] = 1'b0; exp_busy[i] = 1'b0;
      exp_x[i] = 8'd0; exp_y[i] = 7'd0; exp_col[i] = 3'd0;
    end
    n_exp = 0;
    if (!m_first && sx == m_dx && sy == m_dy) return;
    if (!m_first) add_phase(m_dx, m_dy, 3'b000);
    add_phase(sx, sy, 3'b111);
    m_first = 1'b0;
    m_dx = sx;
    m_dy = sy;
  endfunction

  function automatic int count_plots(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (obs_plot[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_busy();
    int n = 0;
    for (int i = 0; i < WIN; i++) if (obs_busy[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic wait_tick();
    @(negedge clock);
    while ((cyc % DIV) != DIV - 1) @(negedge clock);
  endtask

  task automatic observe();
    for (int i = 0; i < WIN; i++) begin
      @(negedge clock);
      obs_plot[i] = plot; obs_busy[i] = busy;
      obs_x[i] = vga_x; obs_y[i] = vga_y; obs_col[i] = vga_colour;
    end
  endtask

  task automatic test_reset();
    #23;
    checks += 5;
    if (plot !== 1'b0)       begin errors++; $display("FAIL reset_plot: got %b need 0", plot); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    if (vga_x !== 8'd0)      begin errors++; $display("FAIL reset_x: got %0d need 0", vga_x); end
    if (vga_y !== 7'd0)      begin errors++; $display("FAIL reset_y: got %0d need 0", vga_y); end
    if (vga_colour !== 3'd0) begin errors++; $display("FAIL reset_colour: got %0d need 0", vga_colour); end
    snoopy_x = 8'd15;
    snoopy_y = 7'd100;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      checks++;
      if (plot !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_before_tick cyc %0d: plot=%b busy=%b need 0 0", cyc, plot, busy);
      end
    end
    $display("pass reset: outputs idle until first tick");
  endtask

  task automatic test_first_draw();
    wait_tick();
    build_expected(15, 100);
    observe();
    for (int i = 0; i < WIN; i++) begin
      checks++;
      if (obs_plot[i] !== exp_plot[i] || obs_busy[i] !== exp_busy[i] ||
          (exp_plot[i] && (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_col[i] !== exp_col[i])) ||
          (!exp_busy[i] && obs_col[i] !== 3'd0)) begin
        errors++;
        $display("FAIL first_draw t+%0d: got plot=%b busy=%b x=%0d y=%0d c=%0d need plot=%b busy=%b x=%0d y=%0d c=%0d",
                 i + 1, obs_plot[i], obs_busy[i], obs_x[i], obs_y[i], obs_col[i],
                 exp_plot[i], exp_busy[i], exp_x[i], exp_y[i], exp_col[i]);
      end
    end
    checks++;
    if (count_plots(0, WIN) != 64) begin
      errors++; $display("FAIL first_draw_count: got %0d plots need 64", count_plots(0, WIN));
    end
    $display("pass first_draw: %0d plots at (15,100)", count_plots(0, WIN));
  endtask

  task automatic test_hold();
    wait_tick();
    build_expected(15, 100);
    observe();
    checks += 2;
    if (count_plots(0, WIN) != 0) begin
      errors++; $display("FAIL hold_plots: got %0d need 0", count_plots(0, WIN));
    end
    if (count_busy() != 0) begin
      errors++; $display("FAIL hold_busy: got %0d busy cycles need 0", count_busy());
    end
    $display("pass hold: %0d plots", count_plots(0, WIN));
  endtask

  task automatic test_move();
    snoopy_x = 8'd16;
    wait_tick();
    build_expected(16, 100);
    observe();
    for (int i = 0; i < WIN; i++) begin
      checks++;
      if (obs_plot[i] !== exp_plot[i] || obs_busy[i] !== exp_busy[i] ||
          (exp_plot[i] && (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_col[i] !== exp_col[i])) ||
          (!exp_busy[i] && obs_col[i] !== 3'd0)) begin
        errors++;
        $display("FAIL move t+%0d: got plot=%b busy=%b x=%0d y=%0d c=%0d need plot=%b busy=%b x=%0d y=%0d c=%0d",
                 i + 1, obs_plot[i], obs_busy[i], obs_x[i], obs_y[i], obs_col[i],
                 exp_plot[i], exp_busy[i], exp_x[i], exp_y[i], exp_col[i]);
      end
    end
    checks++;
    if (count_busy() != 128) begin
      errors++; $display("FAIL move_busy: got %0d busy cycles need 128", count_busy());
    end
    $display("pass move: erase (15,100) draw (16,100), %0d busy cycles", count_busy());
  endtask

  task automatic test_clip();
    snoopy_x = 8'd155;
    snoopy_y = 7'd116;
    wait_tick();
    build_expected(155, 116);
    observe();
    for (int i = 0; i < WIN; i++) begin
      checks++;
      if (obs_plot[i] !== exp_plot[i] || obs_busy[i] !== exp_busy[i] ||
          (exp_plot[i] && (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_col[i] !== exp_col[i]))) begin
        errors++;
        $display("FAIL clip t+%0d: got plot=%b busy=%b x=%0d y=%0d c=%0d need plot=%b busy=%b x=%0d y=%0d c=%0d",
                 i + 1, obs_plot[i], obs_busy[i], obs_x[i], obs_y[i], obs_col[i],
                 exp_plot[i], exp_busy[i], exp_x[i], exp_y[i], exp_col[i]);
      end
    end
    checks++;
    if (count_plots(64, 128) != 20) begin
      errors++; $display("FAIL clip_count: got %0d draw plots need 20", count_plots(64, 128));
    end
    $display("pass clip: %0d draw-phase plots at (155,116)", count_plots(64, 128));
  endtask

  task automatic test_midchange();
    snoopy_x = 8'd16;
    snoopy_y = 7'd100;
    for (int pass = 0; pass < 2; pass++) begin
      wait_tick();
      build_expected(pass == 0 ? 16 : 40, 100);
      fork
        observe();
        begin
          if (pass == 0) begin
            repeat (75) @(negedge clock);
            snoopy_x = 8'd40;
          end
        end
      join
      for (int i = 0; i < WIN; i++) begin
        checks++;
        if (obs_plot[i] !== exp_plot[i] || obs_busy[i] !== exp_busy[i] ||
            (exp_plot[i] && (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_col[i] !== exp_col[i]))) begin
          errors++;
          $display("FAIL midchange%0d t+%0d: got plot=%b busy=%b x=%0d y=%0d c=%0d need plot=%b busy=%b x=%0d y=%0d c=%0d",
                   pass, i + 1, obs_plot[i], obs_busy[i], obs_x[i], obs_y[i], obs_col[i],
                   exp_plot[i], exp_busy[i], exp_x[i], exp_y[i], exp_col[i]);
        end
      end
      $display("pass midchange%0d: %0d plots", pass, count_plots(0, WIN));
    end
  endtask

  task automatic test_reset_mid_erase();
    snoopy_x = 8'd60;
    wait_tick();
    repeat (20) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    checks += 3;
    if (plot !== 1'b0)       begin errors++; $display("FAIL midreset_plot: got %b need 0", plot); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL midreset_busy: got %b need 0", busy); end
    if (vga_colour !== 3'd0) begin errors++; $display("FAIL midreset_colour: got %0d need 0", vga_colour); end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    m_first = 1'b1;
    wait_tick();
    build_expected(60, 100);
    observe();
    for (int i = 0; i < WIN; i++) begin
      checks++;
      if (obs_plot[i] !== exp_plot[i] || obs_busy[i] !== exp_busy[i] ||
          (exp_plot[i] && (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_col[i] !== exp_col[i]))) begin
        errors++;
        $display("FAIL redraw t+%0d: got plot=%b busy=%b x=%0d y=%0d c=%0d need plot=%b busy=%b x=%0d y=%0d c=%0d",
                 i + 1, obs_plot[i], obs_busy[i], obs_x[i], obs_y[i], obs_col[i],
                 exp_plot[i], exp_busy[i], exp_x[i], exp_y[i], exp_col[i]);
      end
    end
    checks++;
    if (count_busy() != 64) begin
      errors++; $display("FAIL redraw_busy: got %0d busy cycles need 64", count_busy());
    end
    $display("pass reset_mid_erase: draw-only pass, %0d busy cycles", count_busy());
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        snoopy_x = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(145, 255)) : 8'($urandom_range(0, 255));
        snoopy_y = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(108, 127)) : 7'($urandom_range(0, 127));
      end
      wait_tick();
      build_expected(int'(snoopy_x), int'(snoopy_y));
      observe();
      for (int i = 0; i < WIN; i++) begin
        checks++;
        if (obs_plot[i] !== exp_plot[i] || obs_busy[i] !== exp_busy[i] ||
            (exp_plot[i] && (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_col[i] !== exp_col[i])) ||
            (!exp_busy[i] && obs_col[i] !== 3'd0)) begin
          errors++;
          $display("FAIL random%0d t+%0d: got plot=%b busy=%b x=%0d y=%0d c=%0d need plot=%b busy=%b x=%0d y=%0d c=%0d",
                   k, i + 1, obs_plot[i], obs_busy[i], obs_x[i], obs_y[i], obs_col[i],
                   exp_plot[i], exp_busy[i], exp_x[i], exp_y[i], exp_col[i]);
        end
      end
      $display("pass random%0d: pos (%0d,%0d), %0d plots, %0d busy", k, m_dx, m_dy,
               count_plots(0, WIN), count_busy());
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_hold();
    test_move();
    test_clip();
    test_midchange();
    test_reset_mid_erase();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
